// File: rtl/fetch_pc_queue_if.sv
// Fetch-side bus: the instruction-memory request path and the decode-facing
// valid/ready queue head, as seen from the PC/queue block (master).
interface fetch_pc_queue_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_req;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;
    logic               out_ready;

    modport master (
        output imem_addr, imem_req, out_valid, out_pc, out_instr,
        input  imem_rdata, out_ready
    );

    modport slave (
        input  imem_addr, imem_req, out_valid, out_pc, out_instr,
        output imem_rdata, out_ready
    );
endinterface

// File: rtl/fetch_pc_queue.sv
// PC generator and fetch buffer: issues sequential or redirected fetches to a
// combinational instruction memory and queues {pc, instr} pairs for decode.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   ST_RUN     | fetching whenever enabled and the queue has room
//   ST_HALTED  | no fetches; queue still drains, redirect still moves pc
module fetch_pc_queue #(
    parameter int              ADDR_W      = 64,
    parameter int              INSTR_W     = 32,
    parameter int              INSTR_BYTES = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = 64'h2000,
    parameter int              DEPTH       = 4,
    localparam int             CNT_W       = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt_req,
    input  logic              resume,
    fetch_pc_queue_if.master  bus,
    output logic              halted,
    output logic [CNT_W-1:0]  count,
    output logic [ADDR_W-1:0] pc
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INSTR_BYTES - 1));

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    state_t             state, state_nx;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [ADDR_W-1:0]  fifo_pc    [DEPTH];
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic               deq, issue, flush;

    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = fifo_pc[rd_ptr];
    assign bus.out_instr = fifo_instr[rd_ptr];
    assign bus.imem_addr = pc;
    assign bus.imem_req  = issue;
    assign halted        = (state == ST_HALTED);

    assign deq   = bus.out_valid & bus.out_ready;
    assign flush = enable & redirect_valid;
    // Full is tolerated when the head leaves in the same cycle.
    assign issue = ~reset & enable & (state == ST_RUN) & ~halt_req & ~redirect_valid
                 & ((count < CNT_W'(DEPTH)) | deq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (enable && halt_req)
            state_nx = ST_HALTED;
        else if (enable && resume && state == ST_HALTED)
            state_nx = ST_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush) begin
            pc     <= redirect_pc & ALIGN_MASK;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (issue) begin
                pc     <= pc + PC_INC;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(issue) - CNT_W'(deq);
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_pc[wr_ptr]    <= pc;
            fifo_instr[wr_ptr] <= bus.imem_rdata;
        end
    end
endmodule

// File: tb/tb_fetch_pc_queue.sv
// Bench for fetch_pc_queue: directed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_fetch_pc_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, rv, hr, rs;
    logic [63:0] rpc;
    logic        halted;
    logic [2:0]  count;
    logic [63:0] pc;

    int checks = 0;
    int errors = 0;

    fetch_pc_queue_if #(.ADDR_W(64), .INSTR_W(32)) bus ();

    fetch_pc_queue #(
        .ADDR_W(64), .INSTR_W(32), .INSTR_BYTES(4), .RESET_PC(64'h2000), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .enable(en), .redirect_valid(rv), .redirect_pc(rpc),
        .halt_req(hr), .resume(rs), .bus(bus), .halted(halted), .count(count), .pc(pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B9) ^ a[63:32] ^ 32'h0F0F_1234;
    endfunction

    assign bus.imem_rdata = instr_of(bus.imem_addr);

    // Reference model: a plain queue of fetched pairs plus pc and halt flag.
    typedef struct { logic [63:0] pc; logic [31:0] instr; } entry_t;
    entry_t      q[$];
    logic [63:0] pc_m;
    bit          halted_m;

    typedef struct {
        logic en, rv; logic [63:0] rpc; logic hr, rs, rdy;
        logic [63:0] e_pc; int e_cnt; logic e_halt, e_req;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic e, input logic r, input logic [63:0] p,
                          input logic h, input logic s, input logic rdy);
        en = e; rv = r; rpc = p; hr = h; rs = s; bus.out_ready = rdy;
    endtask

    function automatic bit exp_issue();
        bit d;
        d = (q.size() > 0) && bus.out_ready;
        return en && !halted_m && !hr && !rv && ((q.size() < DEPTH) || d);
    endfunction

    task automatic model_reset();
        q.delete(); pc_m = 64'h2000; halted_m = 0;
    endtask

    task automatic model_check();
        chk("pc", pc, pc_m);
        chk("count", 64'(count), 64'(q.size()));
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        chk("halted", 64'(halted), 64'(halted_m));
        chk("imem_req", 64'(bus.imem_req), 64'(exp_issue()));
        chk("imem_addr", bus.imem_addr, pc_m);
        if (q.size() > 0) begin
            chk("out_pc", bus.out_pc, q[0].pc);
            chk("out_instr", 64'(bus.out_instr), 64'(q[0].instr));
        end
    endtask

    task automatic model_update();
        bit d, iss;
        d   = (q.size() > 0) && bus.out_ready;
        iss = exp_issue();
        if (en && rv) begin
            q.delete();
            pc_m = rpc & ~64'd3;
        end else begin
            if (d) void'(q.pop_front());
            if (iss) begin
                q.push_back('{pc_m, instr_of(pc_m)});
                pc_m = pc_m + 64'd4;
            end
        end
        if (en && hr)      halted_m = 1;
        else if (en && rs) halted_m = 0;
    endtask

    task automatic cycle_begin();
        @(negedge clk);
        model_check();
    endtask

    task automatic cycle_end();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           en rv rpc                    hr rs rdy  e_pc                  cnt h  req
        tbl[0]  = '{1, 0, 64'h0,                 0, 0, 0,   64'h2000,             0, 0, 1};
        tbl[1]  = '{1, 0, 64'h0,                 0, 0, 0,   64'h2004,             1, 0, 1};
        tbl[2]  = '{1, 0, 64'h0,                 0, 0, 0,   64'h2008,             2, 0, 1};
        tbl[3]  = '{1, 0, 64'h0,                 0, 0, 0,   64'h200c,             3, 0, 1};
        tbl[4]  = '{1, 0, 64'h0,                 0, 0, 0,   64'h2010,             4, 0, 0};
        tbl[5]  = '{1, 0, 64'h0,                 0, 0, 0,   64'h2010,             4, 0, 0};
        tbl[6]  = '{1, 0, 64'h0,                 0, 0, 1,   64'h2010,             4, 0, 1};
        tbl[7]  = '{1, 1, 64'h4003,              0, 0, 0,   64'h2014,             4, 0, 0};
        tbl[8]  = '{1, 0, 64'h0,                 0, 0, 0,   64'h4000,             0, 0, 1};
        tbl[9]  = '{1, 0, 64'h0,                 1, 0, 0,   64'h4004,             1, 0, 0};
        tbl[10] = '{1, 0, 64'h0,                 0, 0, 1,   64'h4004,             1, 1, 0};
        tbl[11] = '{1, 0, 64'h0,                 1, 1, 1,   64'h4004,             0, 1, 0};
        tbl[12] = '{1, 0, 64'h0,                 0, 1, 1,   64'h4004,             0, 1, 0};
        tbl[13] = '{1, 0, 64'h0,                 0, 0, 1,   64'h4004,             0, 0, 1};
        tbl[14] = '{0, 0, 64'h0,                 0, 0, 1,   64'h4008,             1, 0, 0};
        tbl[15] = '{0, 0, 64'h0,                 1, 0, 1,   64'h4008,             0, 0, 0};
        tbl[16] = '{1, 0, 64'h0,                 0, 0, 1,   64'h4008,             0, 0, 1};
        tbl[17] = '{1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 1, 64'h400c,             1, 0, 0};
        tbl[18] = '{1, 0, 64'h0,                 0, 0, 1,   64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 1};
        tbl[19] = '{1, 0, 64'h0,                 0, 0, 1,   64'h0,                1, 0, 1};

        reset = 1'b1;
        set_in(1, 0, 0, 0, 0, 1);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_pc", pc, 64'h2000);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_imem_req", 64'(bus.imem_req), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        chk("rst_hold_count", 64'(count), 64'd0);
        reset = 1'b0;
        model_reset();

        foreach (tbl[i]) begin
            set_in(tbl[i].en, tbl[i].rv, tbl[i].rpc, tbl[i].hr, tbl[i].rs, tbl[i].rdy);
            cycle_begin();
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
            chk($sformatf("vec%0d_halted", i), 64'(halted), 64'(tbl[i].e_halt));
            chk($sformatf("vec%0d_req", i), 64'(bus.imem_req), 64'(tbl[i].e_req));
            cycle_end();
        end

        // Randomized run with phases of varying decode backpressure.
        for (int ph = 0; ph < 12; ph++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 95);
            for (int c = 0; c < 200; c++) begin
                logic [63:0] p;
                if ($urandom_range(0, 3) == 0) p = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                else                           p = {$urandom, $urandom};
                set_in($urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0, p,
                       $urandom_range(0, 29) == 0, $urandom_range(0, 5) == 0,
                       $urandom_range(0, 99) < rdy_pct);
                cycle_begin();
                cycle_end();
            end
        end

        // Build up two entries, then reset asynchronously between edges.
        set_in(1, 1, 64'h8000, 0, 1, 0);
        cycle_begin(); cycle_end();
        set_in(1, 0, 0, 0, 0, 0);
        cycle_begin(); cycle_end();
        cycle_begin(); cycle_end();
        @(negedge clk);
        chk("pre_rst_count", 64'(count), 64'd2);
        chk("pre_rst_pc", pc, 64'h8008);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_pc", pc, 64'h2000);
        chk("async_rst_halted", 64'(halted), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();

        // Streaming at one instruction per cycle with decode always ready.
        for (int i = 0; i < 7; i++) begin
            set_in(1, 0, 0, 0, 0, 1);
            cycle_begin();
            chk($sformatf("stream%0d_addr", i), bus.imem_addr, 64'h2000 + 64'(4 * i));
            if (i > 0) begin
                chk($sformatf("stream%0d_out_pc", i), bus.out_pc, 64'h2000 + 64'(4 * (i - 1)));
                chk($sformatf("stream%0d_instr", i), 64'(bus.out_instr),
                    64'(instr_of(64'h2000 + 64'(4 * (i - 1)))));
            end
            cycle_end();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
